// File: rtl/serial_frame_rx.sv
// Serial frame receiver: start(1) | DATA_W payload | [even parity] | stop(0), one bit per clk.
// Optional parity bit is built only when the PARITY_EN macro is defined.
module serial_frame_rx #(
  parameter int DATA_W    = 8,
  parameter int MSB_FIRST = 0,
  parameter int ERR_W     = 8
) (
  input  logic              clk,
  input  logic              rc_n,
  input  logic              d,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              frame_err,
  output logic              busy,
  output logic [ERR_W-1:0]  err_cnt,
  output logic [1:0]        state_dbg
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [DATA_W-1:0]  sreg;
  logic [CNT_W-1:0]   idx;
  logic               par_ok;

  // Handshake: data_valid and frame_err are one-cycle strobes with no ready.
  // The consumer takes data_out in the cycle data_valid is high; data_out
  // then holds until the next good frame. The two strobes never coincide.

  assign idx = (MSB_FIRST != 0) ? (LAST - cnt) : cnt;

`ifdef PARITY_EN
  logic par_bit;
  assign par_ok = ~(^sreg ^ par_bit);
`else
  assign par_ok = 1'b1;
`endif

  assign busy      = (state != IDLE);
  assign state_dbg = state;

  always_ff @(posedge clk or negedge rc_n) begin
    if (!rc_n) begin
      state      <= IDLE;
      cnt        <= '0;
      sreg       <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      err_cnt    <= '0;
`ifdef PARITY_EN
      par_bit    <= 1'b0;
`endif
    end else begin
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (d) begin
            state <= DATA;
            cnt   <= '0;
          end
        end
        DATA: begin
          sreg[idx] <= d;
          if (cnt == LAST) begin
            cnt   <= '0;
`ifdef PARITY_EN
            state <= PARITY;
`else
            state <= STOP;
`endif
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`ifdef PARITY_EN
        PARITY: begin
          par_bit <= d;
          state   <= STOP;
        end
`endif
        STOP: begin
          // A 1 in the stop slot is an error, never a new start bit.
          if (!d && par_ok) begin
            data_out   <= sreg;
            data_valid <= 1'b1;
          end else begin
            frame_err <= 1'b1;
            if (err_cnt != {ERR_W{1'b1}}) err_cnt <= err_cnt + 1'b1;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
